// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, round constants,
// key-schedule steps and the decryptor state encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        ADDKEY = 3'd2,
        ROUND  = 3'd3,
        FINAL  = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] y;
        y = gf_inv(a);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] forward_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h000000};
        n1 = rk[95:64] ^ n0;
        n2 = rk[63:32] ^ n1;
        n3 = rk[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo forward_step: the last three words fall out by XOR, then w0 needs the recovered w3.
    function automatic logic [127:0] inverse_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0]  ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] next_st
);

    logic [127:0] w_ark;

    // Byte n = 4*col + row sits at bits [127-8n -: 8]; row r rotates right by r columns.
    always_comb begin
        w_ark = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_ark[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*(4*((c-r+4)%4)+r) -: 8])
                                            ^ rk[127-8*(4*c+r) -: 8];
            end
        end
    end

    always_comb begin
        next_st = w_ark;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                next_st[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
            end
        end
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock.
// Optional rk10 cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    input  logic         key_new,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic [2:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, and out_valid holds with stable data_out until out_ready.

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_cnt;
    logic [127:0] r_ct;
    logic [127:0] r_rk;
    logic [127:0] r_st;
    logic [127:0] r_data_out;
    logic         r_out_valid;

    logic         w_cache_hit;
    logic [127:0] w_rk_load;
    logic [127:0] w_rk_fwd;
    logic [127:0] w_rk_inv;
    logic [3:0]   w_inv_idx;
    logic [127:0] w_round;

    assign w_rk_fwd  = forward_step(r_rk, rcon(r_cnt));
    assign w_inv_idx = (r_state == ADDKEY) ? 4'd10 : r_cnt;
    assign w_rk_inv  = inverse_step(r_rk, rcon(w_inv_idx));

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] r_cache;
    logic         r_cache_vld;

    assign w_cache_hit = r_cache_vld && !key_new;
    assign w_rk_load   = w_cache_hit ? r_cache : key;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cache     <= '0;
            r_cache_vld <= 1'b0;
        end else if (r_state == KEYEXP && r_cnt == 4'd10) begin
            r_cache     <= w_rk_fwd;
            r_cache_vld <= 1'b1;
        end
    end
`else
    logic w_unused_key_new;

    assign w_unused_key_new = key_new;
    assign w_cache_hit      = 1'b0;
    assign w_rk_load        = key;
`endif

    aes_inv_round u_inv_round (
        .st      (r_st),
        .rk      (r_rk),
        .last    (r_state == FINAL),
        .next_st (w_round)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = w_cache_hit ? ADDKEY : KEYEXP;
            KEYEXP:  if (r_cnt == 4'd10) w_state_nxt = ADDKEY;
            ADDKEY:  w_state_nxt = ROUND;
            ROUND:   if (r_cnt == 4'd1) w_state_nxt = FINAL;
            FINAL:   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_ct        <= '0;
            r_rk        <= '0;
            r_st        <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_ct  <= data_in;
                        r_rk  <= w_rk_load;
                        r_cnt <= w_cache_hit ? 4'd0 : 4'd1;
                    end
                end
                KEYEXP: begin
                    r_rk  <= w_rk_fwd;
                    r_cnt <= r_cnt + 4'd1;
                end
                ADDKEY: begin
                    r_st  <= r_ct ^ r_rk;
                    r_rk  <= w_rk_inv;
                    r_cnt <= 4'd9;
                end
                ROUND: begin
                    r_st  <= w_round;
                    r_rk  <= w_rk_inv;
                    r_cnt <= r_cnt - 4'd1;
                end
                FINAL: begin
                    r_data_out  <= w_round;
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, cache latency,
// backpressure, mid-block reset and back-to-back blocks against an AES encryption model.
module tb_aes_decrypt_iter;
    import aes_pkg::*;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int LAT_HIT = 11;
`else
    localparam int LAT_HIT = 21;
`endif
    localparam int LAT_MISS = 21;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic         key_new = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] data_out;
    logic [2:0]   dbg_state;

    int           total = 0;
    int           bad = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   sb [256];

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .key_new   (key_new),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (forward AES-128) ----------------
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[4*((i/4 + i%4) % 4) + i%4]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- driver tasks (entered at a negedge with the DUT idle) ----------------
    task automatic send_block(input logic [127:0] ct, input logic [127:0] k, input logic kn,
                              output int lat);
        data_in  = ct;
        key      = k;
        key_new  = kn;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        key_new  = 1'b0;
        data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key      = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++;
        if (data_out !== 128'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        total++;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [127:0] exp;
        exp_q.push_back(PT_C1);
        send_block(CT_C1, KEY_C1, 1'b1, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL c1_data got=%h exp=%h", data_out, exp); end
        total++;
        if (lat !== LAT_MISS) begin bad++; $display("FAIL c1_latency got=%0d exp=%0d", lat, LAT_MISS); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL c1_in_ready_done got=%0b exp=0", in_ready); end
        consume();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL c1_release out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_cache_hit();
        int lat;
        logic [127:0] exp;
        exp_q.push_back(PT_C1);
        send_block(CT_C1, KEY_C1, 1'b0, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL hit_data got=%h exp=%h", data_out, exp); end
        total++;
        if (lat !== LAT_HIT) begin bad++; $display("FAIL hit_latency got=%0d exp=%0d", lat, LAT_HIT); end
        consume();
    endtask

    task automatic test_fips_b();
        int lat;
        logic [127:0] exp;
        exp_q.push_back(PT_B);
        send_block(CT_B, KEY_B, 1'b1, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL b_data got=%h exp=%h", data_out, exp); end
        total++;
        if (lat !== LAT_MISS) begin bad++; $display("FAIL b_latency got=%0d exp=%0d", lat, LAT_MISS); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] exp;
        out_ready = 1'b0;
        exp_q.push_back(PT_C1);
        send_block(CT_C1, KEY_C1, 1'b1, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL bp_data got=%h exp=%h", data_out, exp); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            key_new  = 1'b1;
            data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== exp) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d out_valid=%0b in_ready=%0b data=%h exp 1/0/%h",
                         i, out_valid, in_ready, data_out, exp);
            end
        end
        in_valid = 1'b0;
        key_new  = 1'b0;
        consume();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        total++;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL bp_ignored got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic seen;
        logic [127:0] exp;
        data_in  = CT_C1;
        key      = KEY_C1;
        key_new  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        key_new  = 1'b0;
        repeat (15) @(negedge clk);
        total++;
        if (dbg_state !== ROUND) begin bad++; $display("FAIL abort_in_round got=%0d exp=%0d", dbg_state, ROUND); end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, IDLE); end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%0b exp=0", seen); end
        exp_q.push_back(PT_C1);
        send_block(CT_C1, KEY_C1, 1'b0, lat);
        exp = exp_q.pop_front();
        total++;
        if (data_out !== exp) begin bad++; $display("FAIL abort_next_data got=%h exp=%h", data_out, exp); end
        total++;
        if (lat !== LAT_MISS) begin bad++; $display("FAIL abort_next_latency got=%0d exp=%0d", lat, LAT_MISS); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct_arr [4];
        logic [127:0] pt;
        logic [127:0] exp;
        int           acc_q[$];
        int           acc;
        int           cyc;
        int           n_in;
        int           n_out;
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct_arr[i] = model_encrypt(pt, KEY_C1);
            exp_q.push_back(pt);
        end
        out_ready = 1'b1;
        cyc   = 0;
        n_in  = 0;
        n_out = 0;
        while (n_out < 4 && cyc < 200) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_unexpected data=%h at cycle %0d", data_out, cyc);
                end else begin
                    exp = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    total++;
                    if (data_out !== exp) begin
                        bad++; $display("FAIL b2b_data blk=%0d got=%h exp=%h", n_out, data_out, exp);
                    end
                    total++;
                    if (cyc - acc !== LAT_HIT) begin
                        bad++; $display("FAIL b2b_latency blk=%0d got=%0d exp=%0d", n_out, cyc - acc, LAT_HIT);
                    end
                end
                n_out++;
            end
            if (in_ready === 1'b1) begin
                if (n_in < 4) begin
                    data_in  = ct_arr[n_in];
                    key      = KEY_C1;
                    key_new  = 1'b0;
                    in_valid = 1'b1;
                    acc_q.push_back(cyc + 1);
                    n_in++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++;
        if (n_out !== 4) begin bad++; $display("FAIL b2b_count got=%0d exp=4", n_out); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        build_sbox();
        @(negedge clk);
        test_reset();
        test_fips_c1();
        test_cache_hit();
        test_fips_b();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
